iter_mult_q: RTL and testbench

Parametrised iterative shift-add multiplier with a queued operand pair and a valid/ready output. It replaces the busy-flag 8-bit multiplier used in the datapath.
- Operand pairs enter a synchronous FIFO.
- An engine pops one pair at a time. It adds one shifted multiplicand term per cycle, for each set multiplier bit only (zero bits cost no cycles).
- It produces one full 2*DATA_W product per operation, in signed or unsigned mode.

---
 rtl/iter_mult_pkg.sv | 19 +
 rtl/iter_mult_q_if.sv | 39 +++
 rtl/mult_op_fifo.sv | 50 +++++
 rtl/iter_mult_q.sv | 132 +++++++++++++
 tb/tb_iter_mult_q.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/iter_mult_pkg.sv
// Shared types and width helpers for the
// queued iterative shift-add multiplier.
package iter_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iter_mult_q_if.sv
// Operand-in / product-out handshake bundle
// for iter_mult_q.
interface iter_mult_q_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  import iter_mult_pkg::*;

  localparam int PW = prod_w(DATA_W);
  localparam int CW = cnt_w(FIFO_DEPTH);

  logic              in_vld;
  logic              in_rdy;
  logic              in_signed;
  logic [DATA_W-1:0] in0_data;
  logic [DATA_W-1:0] in1_data;
  logic              out_vld;
  logic              out_rdy;
  logic [PW-1:0]     out_data;
  logic              busy;
  logic [CW-1:0]     fifo_cnt;

  modport master (
    output in_vld, in_signed,
    output in0_data, in1_data,
    output out_rdy,
    input  in_rdy, out_vld,
    input  out_data, busy, fifo_cnt
  );

  modport slave (
    input  in_vld, in_signed,
    input  in0_data, in1_data,
    input  out_rdy,
    output in_rdy, out_vld,
    output out_data, busy, fifo_cnt
  );

endinterface

// File: rtl/mult_op_fifo.sv
// Single-push single-pop synchronous FIFO
// holding {signed, multiplicand, multiplier}.
module mult_op_fifo #(
  parameter int ENT_NUM   = 16,
  parameter int DATA_SIZE = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_SIZE-1:0]         din,
  input  logic                         pop,
  output logic [DATA_SIZE-1:0]         dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(ENT_NUM+1)-1:0] cnt
);
  localparam int PTR_W = $clog2(ENT_NUM);
  localparam int CNT_W = $clog2(ENT_NUM + 1);

  logic [DATA_SIZE-1:0] mem [ENT_NUM];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (cnt == CNT_W'(ENT_NUM));
  assign empty   = (cnt == '0);
  // full refuses a push even alongside a pop
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(do_push)
                 - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/iter_mult_q.sv
// Queued iterative shift-add multiplier: one
// cycle per set multiplier bit, signed/unsigned.
module iter_mult_q
  import iter_mult_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  iter_mult_q_if.slave bus
);
  localparam int PW = prod_w(DATA_W);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_W);
  localparam int ES = 2 * DATA_W + 1;

  state_t            state;
  state_t            state_nx;
  state_t            ld_state;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     a;
  logic [PW-1:0]     a_ld;
  logic [PW-1:0]     shifted;
  logic [PW-1:0]     term;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] mask_nx;
  logic              sgn;
  logic [IW-1:0]     idx;

  logic [ES-1:0]     f_din;
  logic [ES-1:0]     f_dout;
  logic              f_full;
  logic              f_empty;
  logic [CW-1:0]     f_cnt;
  logic              pop;
  logic              ld_sgn;
  logic [DATA_W-1:0] ld_a;
  logic [DATA_W-1:0] ld_b;

  assign f_din = {bus.in_signed,
                  bus.in0_data,
                  bus.in1_data};

  mult_op_fifo #(
    .ENT_NUM  (FIFO_DEPTH),
    .DATA_SIZE(ES)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (bus.in_vld),
    .din  (f_din),
    .pop  (pop),
    .dout (f_dout),
    .full (f_full),
    .empty(f_empty),
    .cnt  (f_cnt)
  );

  assign {ld_sgn, ld_a, ld_b} = f_dout;

  assign a_ld = ld_sgn
    ? {{DATA_W{ld_a[DATA_W-1]}}, ld_a}
    : {{DATA_W{1'b0}}, ld_a};

  assign ld_state = (ld_b == '0) ? ST_DONE
                                 : ST_CALC;

  assign pop = ~f_empty &
    ((state == ST_IDLE) |
     ((state == ST_DONE) & bus.out_rdy));

  // descending scan so the lowest set bit wins
  always_comb begin
    idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  // multiplier MSB weighs -2^(W-1) when signed
  assign shifted = a << idx;
  assign term = (sgn && idx == IW'(DATA_W - 1))
    ? (~shifted + PW'(1)) : shifted;
  assign mask_nx = mask & (mask - DATA_W'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (pop) state_nx = ld_state;
      end
      ST_CALC: begin
        if (mask_nx == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_rdy)
          state_nx = pop ? ld_state : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      a    <= '0;
      mask <= '0;
      sgn  <= 1'b0;
    end else if (pop) begin
      acc  <= '0;
      a    <= a_ld;
      mask <= ld_b;
      sgn  <= ld_sgn;
    end else if (state == ST_CALC) begin
      acc  <= acc + term;
      mask <= mask_nx;
    end
  end

  assign bus.in_rdy   = ~f_full;
  assign bus.out_vld  = (state == ST_DONE);
  assign bus.out_data = acc;
  assign bus.fifo_cnt = f_cnt;
  assign bus.busy     = (state != ST_IDLE) | ~f_empty;

endmodule

// File: tb/tb_iter_mult_q.sv
// Scoreboard bench for iter_mult_q: directed
// vectors plus a randomised stall soak.
module tb_iter_mult_q;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  iter_mult_q_if #(
    .DATA_W(8), .FIFO_DEPTH(16)
  ) bus ();

  iter_mult_q #(
    .DATA_W(8), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          results  = 0;
  logic [15:0] exp_q [$];
  bit          stalled  = 0;
  logic [15:0] held;
  bit          gen_done = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model(
      input logic s,
      input logic [7:0] x,
      input logic [7:0] y);
    logic [15:0] ex, ey;
    ex = s ? {{8{x[7]}}, x} : {8'h00, x};
    ey = s ? {{8{y[7]}}, y} : {8'h00, y};
    return ex * ey;
  endfunction

  // Monitor: compare every accepted product
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_vld", bus.out_vld, 1);
        chk("stall_data", bus.out_data, held);
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %0h expected none",
                   bus.out_data);
        end else begin
          chk("product", bus.out_data,
              exp_q.pop_front());
          results++;
        end
      end
      stalled = bus.out_vld && !bus.out_rdy;
      held    = bus.out_data;
    end
  end

  // Called at posedge+1; returns at posedge+1
  task automatic push(input logic s,
                      input logic [7:0] x,
                      input logic [7:0] y,
                      input logic [15:0] e,
                      output bit ok);
    bus.in_vld    = 1'b1;
    bus.in_signed = s;
    bus.in0_data  = x;
    bus.in1_data  = y;
    ok = bus.in_rdy;
    if (ok) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (!bus.out_vld && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.out_vld) begin
      checks++;
      failures++;
      $display("FAIL wait_vld: got timeout expected out_vld");
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    int acc_cnt;
    int r0;
    int vc;

    bus.in_vld    = 1'b0;
    bus.in_signed = 1'b0;
    bus.in0_data  = '0;
    bus.in1_data  = '0;
    bus.out_rdy   = 1'b0;

    #12;
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fifo_cnt", bus.fifo_cnt, 0);
    step();
    rst = 1'b0;
    step();

    // 3*5 unsigned, latency 1+popcount
    bus.out_rdy = 1'b1;
    push(0, 8'h03, 8'h05, 16'h000F, ok);
    wait_vld(n);
    chk("lat_3x5", n, 3);
    step();
    chk("idle_vld", bus.out_vld, 0);
    chk("idle_busy", bus.busy, 0);

    // back-to-back signed then unsigned
    push(1, 8'hFD, 8'hFE, 16'h0006, ok);
    push(0, 8'hFD, 8'hFE, 16'hFB06, ok);
    wait_vld(n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.out_vld && n < 50);
    chk("b2b_gap", n, 8);
    step();

    // signed extremes and zero multiplier
    push(1, 8'h80, 8'h80, 16'h4000, ok);
    wait_vld(n);
    chk("lat_min_min", n, 2);
    step();
    push(1, 8'h7F, 8'h80, 16'hC080, ok);
    wait_vld(n);
    chk("lat_max_min", n, 2);
    step();
    push(0, 8'h12, 8'h00, 16'h0000, ok);
    wait_vld(n);
    chk("lat_zero", n, 1);
    step();

    // fill the FIFO while the output stalls
    bus.out_rdy = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      push(0, 8'h01, 8'h01, 16'h0001, ok);
      acc_cnt += int'(ok);
    end
    chk("fill_accepted", acc_cnt, 17);
    chk("fill_cnt", bus.fifo_cnt, 16);
    chk("fill_in_rdy", bus.in_rdy, 0);
    chk("fill_out_vld", bus.out_vld, 1);
    chk("fill_busy", bus.busy, 1);
    r0 = results;
    bus.out_rdy = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    step();
    chk("drain_results", results - r0, 17);
    chk("drain_busy", bus.busy, 0);
    chk("drain_cnt", bus.fifo_cnt, 0);

    // asynchronous reset mid-calculation
    push(0, 8'hFF, 8'hFF, 16'hFE01, ok);
    for (int i = 0; i < 4; i++)
      push(0, 8'h02, 8'h03, 16'h0006, ok);
    chk("pre_rst_vld", bus.out_vld, 0);
    chk("pre_rst_cnt", bus.fifo_cnt, 4);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_vld", bus.out_vld, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cnt", bus.fifo_cnt, 0);
    chk("mid_rst_in_rdy", bus.in_rdy, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vc = 0;
    repeat (15) begin
      step();
      if (bus.out_vld) vc++;
    end
    chk("stale_vld", vc, 0);
    push(0, 8'h02, 8'h03, 16'h0006, ok);
    wait_vld(n);
    chk("lat_post_rst", n, 3);
    step();

    // random pairs, random output stalls
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic       s;
          logic [7:0] x, y;
          int         tries;
          if ($urandom_range(0, 3) == 0) step();
          s = 1'($urandom_range(0, 1));
          x = 8'($urandom);
          y = 8'($urandom);
          tries = 0;
          do begin
            push(s, x, y, model(s, x, y), ok);
            tries++;
          end while (!ok && tries < 100);
        end
        gen_done = 1;
      end
      begin
        int guard = 0;
        while ((!gen_done || exp_q.size() != 0)
               && guard < 5000) begin
          step();
          bus.out_rdy = 1'($urandom_range(0, 1));
          guard++;
        end
        bus.out_rdy = 1'b1;
      end
    join
    repeat (3) step();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
